// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle RV32I core: IF/ID/EX/MEM/WB sequencing,
// per-phase cycle counting, datapath enables/selects and ECALL halt.
module multicycle_ctrl #(
  parameter int unsigned IF_CYCLES  = 4,
  parameter int unsigned EX_CYCLES  = 2,
  parameter int unsigned MEM_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic       bcond,
  input  logic       halt_req,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       halted,
  output logic       illegal,
  output logic [2:0] state_o
);

  localparam int unsigned MAX_IE  = (IF_CYCLES > EX_CYCLES) ? IF_CYCLES : EX_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_IE > MEM_CYCLES) ? MAX_IE : MEM_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] IF_LAST  = CNT_W'(IF_CYCLES - 1);
  localparam logic [CNT_W-1:0] EX_LAST  = CNT_W'(EX_CYCLES - 1);
  localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CL_R       = 4'd0,
    CL_I       = 4'd1,
    CL_LOAD    = 4'd2,
    CL_STORE   = 4'd3,
    CL_BRANCH  = 4'd4,
    CL_JAL     = 4'd5,
    CL_JALR    = 4'd6,
    CL_ECALL   = 4'd7,
    CL_ILLEGAL = 4'd8
  } class_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  class_e             class_q, class_d;
  class_e             dec_class;

  logic       pc_write_c, i_or_d_c, mem_read_c, mem_write_c, ir_write_c;
  logic       reg_write_c, alu_src_a_c, instr_done_c, halted_c, illegal_c;
  logic [1:0] pc_source_c, mem_to_reg_c, alu_src_b_c, alu_op_c;

  // Opcode to instruction class
  always_comb begin
    case (opcode)
      7'b0110011: dec_class = CL_R;
      7'b0010011: dec_class = CL_I;
      7'b0000011: dec_class = CL_LOAD;
      7'b0100011: dec_class = CL_STORE;
      7'b1100011: dec_class = CL_BRANCH;
      7'b1101111: dec_class = CL_JAL;
      7'b1100111: dec_class = CL_JALR;
      7'b1110011: dec_class = CL_ECALL;
      default:    dec_class = CL_ILLEGAL;
    endcase
  end

  // State, phase counter and latched instruction class
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IF;
      cnt_q   <= '0;
      class_q <= CL_ILLEGAL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      class_q <= class_d;
    end
  end

  // Next-state and datapath controls from state, counter and class
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    class_d      = class_q;
    pc_write_c   = 1'b0;
    pc_source_c  = 2'd0;
    i_or_d_c     = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    mem_to_reg_c = 2'd0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'd0;
    alu_op_c     = 2'd0;
    instr_done_c = 1'b0;
    halted_c     = 1'b0;
    illegal_c    = 1'b0;

    case (state_q)
      ST_IF: begin
        mem_read_c = 1'b1;
        if (cnt_q == IF_LAST) begin
          ir_write_c = 1'b1;
          state_d    = ST_ID;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_ID: begin
        // ALUOut captures PC+imm as the branch/jump target
        alu_src_b_c = 2'd2;
        class_d     = dec_class;
        case (dec_class)
          CL_ECALL: begin
            instr_done_c = 1'b1;
            if (halt_req) begin
              state_d = ST_HALT;
            end else begin
              pc_write_c  = 1'b1;
              pc_source_c = 2'd2;
              state_d     = ST_IF;
            end
          end
          CL_ILLEGAL: begin
            instr_done_c = 1'b1;
            illegal_c    = 1'b1;
            pc_write_c   = 1'b1;
            pc_source_c  = 2'd2;
            state_d      = ST_IF;
          end
          default: state_d = ST_EX;
        endcase
      end

      ST_EX: begin
        case (class_q)
          CL_R: begin
            alu_src_a_c = 1'b1;
            alu_op_c    = 2'd2;
          end
          CL_I: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = 2'd2;
            alu_op_c    = 2'd2;
          end
          CL_LOAD, CL_STORE, CL_JALR: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = 2'd2;
          end
          CL_BRANCH: begin
            alu_src_a_c = 1'b1;
            alu_op_c    = 2'd1;
          end
          default: ;
        endcase
        if (cnt_q == EX_LAST) begin
          if (class_q == CL_BRANCH) begin
            pc_write_c   = 1'b1;
            pc_source_c  = bcond ? 2'd1 : 2'd2;
            instr_done_c = 1'b1;
            state_d      = ST_IF;
          end else if (class_q == CL_LOAD || class_q == CL_STORE) begin
            state_d = ST_MEM;
          end else begin
            state_d = ST_WB;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_MEM: begin
        i_or_d_c    = 1'b1;
        mem_read_c  = (class_q == CL_LOAD);
        mem_write_c = (class_q == CL_STORE);
        if (cnt_q == MEM_LAST) begin
          if (class_q == CL_STORE) begin
            pc_write_c   = 1'b1;
            pc_source_c  = 2'd2;
            instr_done_c = 1'b1;
            state_d      = ST_IF;
          end else begin
            state_d = ST_WB;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WB: begin
        reg_write_c  = 1'b1;
        pc_write_c   = 1'b1;
        instr_done_c = 1'b1;
        state_d      = ST_IF;
        if (class_q == CL_LOAD) begin
          mem_to_reg_c = 2'd1;
          pc_source_c  = 2'd2;
        end else if (class_q == CL_JAL || class_q == CL_JALR) begin
          mem_to_reg_c = 2'd2;
          pc_source_c  = 2'd1;
        end else begin
          pc_source_c  = 2'd2;
        end
      end

      ST_HALT: halted_c = 1'b1;

      default: state_d = ST_IF;
    endcase
  end

  // All outputs held at 0 while reset is asserted
  assign pc_write   = reset_n & pc_write_c;
  assign pc_source  = reset_n ? pc_source_c : 2'd0;
  assign i_or_d     = reset_n & i_or_d_c;
  assign mem_read   = reset_n & mem_read_c;
  assign mem_write  = reset_n & mem_write_c;
  assign ir_write   = reset_n & ir_write_c;
  assign reg_write  = reset_n & reg_write_c;
  assign mem_to_reg = reset_n ? mem_to_reg_c : 2'd0;
  assign alu_src_a  = reset_n & alu_src_a_c;
  assign alu_src_b  = reset_n ? alu_src_b_c : 2'd0;
  assign alu_op     = reset_n ? alu_op_c : 2'd0;
  assign instr_done = reset_n & instr_done_c;
  assign halted     = reset_n & halted_c;
  assign illegal    = reset_n & illegal_c;
  assign state_o    = reset_n ? 3'(state_q) : 3'd0;

endmodule
